// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 128-bit memory port between icache reads and dcache reads/write-backs
module mem_port_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         I_READ,
  input  logic [27:0]  I_ADDR,
  output logic [127:0] I_READDATA,
  output logic         I_BUSYWAIT,
  input  logic         D_READ,
  input  logic         D_WRITE,
  input  logic [27:0]  D_ADDR,
  input  logic [127:0] D_WRITEDATA,
  output logic [127:0] D_READDATA,
  output logic         D_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDR,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT,
  output logic         ERR
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;
  state_t state, state_n;
  logic grant, last_grant, ack, i_req, d_req, pick_d, done, timed_out;
  logic [CNT_W-1:0] cnt;
  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;
  // grant/last_grant: 1 = data cache, 0 = instruction cache
  assign pick_d = d_req & (~i_req | (PRIORITY_MODE == 0) | ~last_grant);
  assign done = (state == WAIT) & ~MEM_BUSYWAIT;
  assign timed_out = (state == WAIT) & MEM_BUSYWAIT & (TIMEOUT_CYCLES != 0) &
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_comb begin
    ack = state == RELEASE;
    state_n = state == IDLE  ? ((i_req | d_req) ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? ((done | timed_out) ? RELEASE : WAIT) : IDLE;
    I_BUSYWAIT = i_req & ~(ack & ~grant);
    D_BUSYWAIT = d_req & ~(ack & grant);
  end
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      grant <= 1'b0;
      last_grant <= 1'b0;
      cnt <= '0;
      MEM_READ <= 1'b0;
      MEM_WRITE <= 1'b0;
      MEM_ADDR <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA <= '0;
      D_READDATA <= '0;
      ERR <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && D_READ && D_WRITE) ERR <= 1'b1;
      // a simultaneous D read+write is serviced as the write first
      if (state == IDLE && (i_req | d_req)) begin
        grant <= pick_d;
        MEM_ADDR <= pick_d ? D_ADDR : I_ADDR;
        MEM_READ <= ~(pick_d & D_WRITE);
        MEM_WRITE <= pick_d & D_WRITE;
        if (pick_d & D_WRITE) MEM_WRITEDATA <= D_WRITEDATA;
      end
      if (done) begin
        MEM_READ <= 1'b0;
        MEM_WRITE <= 1'b0;
        last_grant <= grant;
        if (MEM_READ & grant) D_READDATA <= MEM_READDATA;
        if (MEM_READ & ~grant) I_READDATA <= MEM_READDATA;
      end
      if (timed_out) begin
        MEM_READ <= 1'b0;
        MEM_WRITE <= 1'b0;
        ERR <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench; instance 0 is fixed-priority with timeout 5, instance 1 round-robin
module tb_mem_port_arbiter;
  typedef struct {
    bit port;
    bit wr;
    logic [27:0] addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic i_read[2], d_read[2], d_write[2], stuck[2];
  logic i_bw[2], d_bw[2], mem_read[2], mem_write[2], mem_bw[2], err[2];
  logic [27:0] i_addr[2], d_addr[2], mem_addr[2];
  logic [127:0] d_writedata[2], i_rdata[2], d_rdata[2], mem_wdata[2], mem_rd[2];
  logic [127:0] last_i[2], last_d[2];
  exp_t sb[$];
  int passed = 0, fails = 0, total = 0;
  always #5 clk = ~clk;
  function automatic logic [127:0] f(logic [27:0] a);
    return {4{32'hA5A5A5A5}} ^ {100'd0, a - 28'h10};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    logic [3:0] mcnt;
    always @(posedge clk) mcnt <= (mem_read[g] | mem_write[g]) ? mcnt + 4'd1 : 4'd0;
    assign mem_bw[g] = (mem_read[g] | mem_write[g]) & (stuck[g] | (mcnt < 4'd3));
    assign mem_rd[g] = f(mem_addr[g]);
    mem_port_arbiter #(.PRIORITY_MODE(g), .TIMEOUT_CYCLES(g == 0 ? 5 : 0), .CNT_W(8)) dut (
      .CLK(clk), .RESET(rst),
      .I_READ(i_read[g]), .I_ADDR(i_addr[g]), .I_READDATA(i_rdata[g]), .I_BUSYWAIT(i_bw[g]),
      .D_READ(d_read[g]), .D_WRITE(d_write[g]), .D_ADDR(d_addr[g]), .D_WRITEDATA(d_writedata[g]),
      .D_READDATA(d_rdata[g]), .D_BUSYWAIT(d_bw[g]),
      .MEM_READ(mem_read[g]), .MEM_WRITE(mem_write[g]), .MEM_ADDR(mem_addr[g]),
      .MEM_WRITEDATA(mem_wdata[g]), .MEM_READDATA(mem_rd[g]), .MEM_BUSYWAIT(mem_bw[g]),
      .ERR(err[g])
    );
  end
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(int g, bit port, bit wr, logic [27:0] a, logic [127:0] wd, bit to);
    exp_t e;
    e.port = port;
    e.wr = wr;
    e.addr = a;
    e.wdata = wd;
    if (!port) begin
      i_read[g] = 1'b1;
      i_addr[g] = a;
      e.rdata = to ? last_i[g] : f(a);
      last_i[g] = e.rdata;
    end else begin
      d_addr[g] = a;
      if (wr) begin
        d_write[g] = 1'b1;
        d_writedata[g] = wd;
        e.rdata = last_d[g];
      end else begin
        d_read[g] = 1'b1;
        e.rdata = to ? last_d[g] : f(a);
        last_d[g] = e.rdata;
      end
    end
    sb.push_back(e);
  endtask
  task automatic xfer(int g, int exp_len, bit to, bit keep);
    exp_t e;
    int n = 0;
    int m = 0;
    e = sb.pop_front();
    while (!(mem_read[g] | mem_write[g]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("grant_latency", 128'(n), 128'd1);
    chk("mem_read", 128'(mem_read[g]), 128'(!e.wr));
    chk("mem_write", 128'(mem_write[g]), 128'(e.wr));
    chk("mem_addr", 128'(mem_addr[g]), 128'(e.addr));
    if (e.wr) chk("mem_wdata", mem_wdata[g], e.wdata);
    while ((e.port ? d_bw[g] : i_bw[g]) && m < 40) begin
      @(negedge clk);
      m++;
    end
    chk("busy_len", 128'(m), 128'(exp_len));
    chk("strobes_off", 128'({mem_read[g], mem_write[g]}), 128'd0);
    chk("readdata", e.port ? d_rdata[g] : i_rdata[g], e.rdata);
    if (to) chk("err_timeout", 128'(err[g]), 128'd1);
    @(negedge clk);
    chk("bw_one_cycle", 128'(e.port ? d_bw[g] : i_bw[g]), 128'd1);
    if (!keep) begin
      if (!e.port) i_read[g] = 1'b0;
      else if (e.wr) d_write[g] = 1'b0;
      else d_read[g] = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      i_read[g] = 0; d_read[g] = 0; d_write[g] = 0; stuck[g] = 0;
      i_addr[g] = '0; d_addr[g] = '0; d_writedata[g] = '0;
      last_i[g] = '0; last_d[g] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("rst_strobes", 128'({mem_read[g], mem_write[g]}), 128'd0);
      chk("rst_err", 128'(err[g]), 128'd0);
      chk("rst_addr", 128'(mem_addr[g]), 128'd0);
      chk("rst_rdata", i_rdata[g] | d_rdata[g], 128'd0);
      chk("rst_bw", 128'({i_bw[g], d_bw[g]}), 128'd0);
    end
    // single icache read
    req(0, 0, 0, 28'h0000010, '0, 0);
    xfer(0, 4, 0, 0);
    chk("t1_rdata_a5", i_rdata[0], {4{32'hA5A5A5A5}});
    chk("t1_d_bw", 128'(d_bw[0]), 128'd0);
    // fixed priority tie: D then I with no extra gap
    req(0, 1, 0, 28'h0000020, '0, 0);
    req(0, 0, 0, 28'h0000030, '0, 0);
    xfer(0, 4, 0, 0);
    chk("t2_loser_bw", 128'(i_bw[0]), 128'd1);
    xfer(0, 4, 0, 0);
    // write-back
    req(0, 1, 1, 28'h0000123, {4{32'hDEADBEEF}}, 0);
    xfer(0, 4, 0, 0);
    chk("t4_err_clear", 128'(err[0]), 128'd0);
    // memory stuck busy -> timeout abort
    stuck[0] = 1'b1;
    req(0, 0, 0, 28'h0000040, '0, 1);
    xfer(0, 6, 1, 0);
    stuck[0] = 1'b0;
    // round-robin with both held for four transfers
    req(1, 1, 0, 28'h0000050, '0, 0);
    req(1, 0, 0, 28'h0000060, '0, 0);
    req(1, 1, 0, 28'h0000050, '0, 0);
    req(1, 0, 0, 28'h0000060, '0, 0);
    xfer(1, 4, 0, 1);
    xfer(1, 4, 0, 1);
    xfer(1, 4, 0, 1);
    xfer(1, 4, 0, 0);
    d_read[1] = 1'b0;
    chk("t3_err_clear", 128'(err[1]), 128'd0);
    // D_READ and D_WRITE together: error, write first, then read
    req(1, 1, 1, 28'h0000070, {4{32'h0BADF00D}}, 0);
    req(1, 1, 0, 28'h0000070, '0, 0);
    xfer(1, 4, 0, 0);
    chk("dual_err", 128'(err[1]), 128'd1);
    xfer(1, 4, 0, 0);
    // reset while waiting on memory
    stuck[0] = 1'b1;
    i_addr[0] = 28'h0000080;
    i_read[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_in_wait", 128'(mem_read[0]), 128'd1);
    rst = 1'b1;
    i_read[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stuck[0] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("t6_strobes", 128'({mem_read[g], mem_write[g]}), 128'd0);
      chk("t6_err", 128'(err[g]), 128'd0);
      chk("t6_rdata", i_rdata[g] | d_rdata[g], 128'd0);
      chk("t6_addr", 128'(mem_addr[g]), 128'd0);
    end
    @(negedge clk);
    chk("t6_idle", 128'(mem_read[0]), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
